// File: rtl/ring_pkg.sv
// Shared definitions for the ring sequence monitor: state encoding,
// default ring width and rotation-direction constants.
package ring_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam int unsigned DIR_LEFT  = 0;
  localparam int unsigned DIR_RIGHT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } state_t;

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot qualifier and encoder for the sampled ring value.
module onehot_decode #(
  parameter int unsigned WIDTH = ring_pkg::DEFAULT_WIDTH,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             is_onehot,
  output logic [IDX_W-1:0] index
);

  // Exactly one bit set; zero and multi-hot both fail.
  always_comb begin
    is_onehot = ($countones(vec) == 1);
  end

  // Position of the set bit; only meaningful when is_onehot is high.
  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ring_sequence_monitor.sv
// Checks that a ring counter's Q bus stays one-hot and rotates by one
// position per enabled cycle; reports lock, sticky fault, error pulses,
// encoded position and a saturating error count.
module ring_sequence_monitor
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned DIR      = DIR_LEFT
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         Q_in,
  input  logic                     sample_en,
  input  logic                     err_clr,
  output logic                     locked,
  output logic                     fault,
  output logic                     onehot_err,
  output logic                     step_err,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned POS_W  = $clog2(WIDTH);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   prev_d;
  logic [GOOD_W-1:0]  good_q;
  logic [GOOD_W-1:0]  good_d;
  logic [GOOD_W-1:0]  good_inc;
  logic [POS_W-1:0]   pos_d;
  logic               onehot_err_d;
  logic               step_err_d;
  logic               fault_d;
  logic [ERR_W-1:0]   count_base;
  logic [ERR_W-1:0]   count_d;
  logic               err_any;

  logic               is_onehot;
  logic [POS_W-1:0]   index;
  logic [WIDTH-1:0]   expected;
  logic               step_bad;

  onehot_decode #(
    .WIDTH (WIDTH),
    .IDX_W (POS_W)
  ) u_decode (
    .vec       (Q_in),
    .is_onehot (is_onehot),
    .index     (index)
  );

  // Expected successor of the previous sample; a repeat of prev also fails.
  assign expected = (DIR == DIR_RIGHT) ? {prev_q[0], prev_q[WIDTH-1:1]}
                                       : {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign step_bad = is_onehot && (Q_in != expected);
  assign good_inc = good_q + GOOD_W'(1);

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the FSM only moves on enabled samples.
  always_comb begin
    state_d = state_q;
    if (sample_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_onehot) state_d = ST_SYNC;
        end
        ST_SYNC, ST_LOST: begin
          if (!is_onehot) begin
            state_d = ST_IDLE;
          end else if (!step_bad && (good_inc == GOOD_W'(LOCK_CNT))) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (!is_onehot) begin
            state_d = ST_IDLE;
          end else if (step_bad) begin
            state_d = ST_LOST;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values; err_clr acts on every edge but a
  // same-edge error still lands on top of the cleared values.
  always_comb begin
    prev_d       = prev_q;
    good_d       = good_q;
    pos_d        = pos;
    onehot_err_d = 1'b0;
    step_err_d   = 1'b0;
    err_any      = 1'b0;
    fault_d      = fault & ~err_clr;
    count_base   = err_clr ? '0 : err_count;
    count_d      = count_base;

    if (sample_en) begin
      if (state_q == ST_IDLE) begin
        if (is_onehot) begin
          prev_d = Q_in;
          pos_d  = index;
          good_d = '0;
        end
      end else if (!is_onehot) begin
        onehot_err_d = 1'b1;
        err_any      = 1'b1;
        good_d       = '0;
      end else begin
        prev_d = Q_in;
        pos_d  = index;
        if (step_bad) begin
          step_err_d = 1'b1;
          err_any    = 1'b1;
          good_d     = '0;
        end else if (state_q != ST_LOCKED) begin
          good_d = good_inc;
        end
      end
    end

    if (err_any) begin
      if (!(&count_base)) count_d = count_base + ERR_W'(1);
      if ((state_q == ST_LOCKED) || (state_q == ST_LOST)) fault_d = 1'b1;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      prev_q     <= '0;
      good_q     <= '0;
      pos        <= '0;
      onehot_err <= 1'b0;
      step_err   <= 1'b0;
      fault      <= 1'b0;
      err_count  <= '0;
    end else begin
      prev_q     <= prev_d;
      good_q     <= good_d;
      pos        <= pos_d;
      onehot_err <= onehot_err_d;
      step_err   <= step_err_d;
      fault      <= fault_d;
      err_count  <= count_d;
    end
  end

  // Status flags decoded straight from the state register.
  assign locked    = (state_q == ST_LOCKED);
  assign pos_valid = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Bench for ring_sequence_monitor: directed vector table, a saturation
// sequence on a narrow-counter instance, then randomized traffic checked
// against a position-arithmetic reference model.
module tb_ring_sequence_monitor;

  localparam int W = 4;
  localparam int LOCKN = 4;

  logic         CLK;
  logic         Reset;
  logic [W-1:0] Q_in;
  logic         sample_en;
  logic         err_clr;

  logic       locked, fault, onehot_err, step_err, pos_valid;
  logic [1:0] pos;
  logic [7:0] err_count;

  logic       s_locked, s_fault, s_onehot_err, s_step_err, s_pos_valid;
  logic [1:0] s_pos;
  logic [1:0] s_err_count;

  ring_sequence_monitor u_dut (
    .CLK(CLK), .Reset(Reset), .Q_in(Q_in), .sample_en(sample_en), .err_clr(err_clr),
    .locked(locked), .fault(fault), .onehot_err(onehot_err), .step_err(step_err),
    .pos(pos), .pos_valid(pos_valid), .err_count(err_count)
  );

  ring_sequence_monitor #(.ERR_W(2)) u_sat (
    .CLK(CLK), .Reset(Reset), .Q_in(Q_in), .sample_en(sample_en), .err_clr(err_clr),
    .locked(s_locked), .fault(s_fault), .onehot_err(s_onehot_err), .step_err(s_step_err),
    .pos(s_pos), .pos_valid(s_pos_valid), .err_count(s_err_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks ring position as an integer and applies the
  // monitor rules directly.
  typedef enum {M_IDLE, M_SYNC, M_LOCKED, M_LOST} mode_t;
  mode_t m_mode = M_IDLE;
  int m_good = 0, m_prev = 0, m_pos = 0, m_cnt = 0, m_cnt2 = 0;
  bit m_fault = 0, m_oh = 0, m_st = 0;

  task automatic model_step(input bit r, input bit e, input bit c, input logic [W-1:0] q);
    int ones, idx;
    bit err;
    mode_t old;
    if (r) begin
      m_mode = M_IDLE; m_good = 0; m_prev = 0; m_pos = 0;
      m_cnt = 0; m_cnt2 = 0; m_fault = 0; m_oh = 0; m_st = 0;
      return;
    end
    m_oh = 0; m_st = 0; err = 0;
    if (c) begin m_fault = 0; m_cnt = 0; m_cnt2 = 0; end
    if (!e) return;
    ones = $countones(q);
    idx = 0;
    for (int i = 0; i < W; i++) if (q[i]) idx = i;
    old = m_mode;
    if (m_mode == M_IDLE) begin
      if (ones == 1) begin
        m_mode = M_SYNC; m_prev = idx; m_pos = idx; m_good = 0;
      end
    end else if (ones != 1) begin
      m_oh = 1; err = 1; m_good = 0; m_mode = M_IDLE;
    end else if (idx != (m_prev + 1) % W) begin
      m_st = 1; err = 1; m_good = 0; m_prev = idx; m_pos = idx;
      if (m_mode == M_LOCKED) m_mode = M_LOST;
    end else begin
      m_prev = idx; m_pos = idx;
      if (m_mode != M_LOCKED) begin
        m_good++;
        if (m_good == LOCKN) m_mode = M_LOCKED;
      end
    end
    if (err) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
      if (old == M_LOCKED || old == M_LOST) m_fault = 1;
    end
  endtask

  task automatic check_model();
    chk("locked", int'(locked), int'(m_mode == M_LOCKED));
    chk("pos_valid", int'(pos_valid), int'(m_mode != M_IDLE));
    chk("fault", int'(fault), int'(m_fault));
    chk("onehot_err", int'(onehot_err), int'(m_oh));
    chk("step_err", int'(step_err), int'(m_st));
    chk("pos", int'(pos), m_pos);
    chk("err_count", int'(err_count), m_cnt);
    chk("sat_err_count", int'(s_err_count), m_cnt2);
    chk("sat_locked", int'(s_locked), int'(m_mode == M_LOCKED));
  endtask

  task automatic step(input bit r, input bit e, input bit c, input logic [W-1:0] q);
    Reset = r; sample_en = e; err_clr = c; Q_in = q;
    @(posedge CLK);
    cyc++;
    model_step(r, e, c, q);
    #1;
    check_model();
  endtask

  typedef struct {
    bit         rst, en, clr;
    logic [3:0] q;
    bit         lk, pv, ft, oh, st;
    int         p, cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit en, bit clr, logic [3:0] q,
                             bit lk, bit pv, bit ft, bit oh, bit st, int p, int cnt);
    vec_t t;
    t.rst = rst; t.en = en; t.clr = clr; t.q = q;
    t.lk = lk; t.pv = pv; t.ft = ft; t.oh = oh; t.st = st; t.p = p; t.cnt = cnt;
    return t;
  endfunction

  initial begin
    Reset = 1'b1; sample_en = 1'b0; err_clr = 1'b0; Q_in = '0;

    //            rst en clr q        lk pv ft oh st pos cnt
    tbl.push_back(v(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 4'b0100, 0, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 1, 0, 4'b1000, 0, 1, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 1, 0, 4'b0001, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b0100, 0, 1, 1, 0, 1, 2, 1));
    tbl.push_back(v(0, 1, 0, 4'b1000, 0, 1, 1, 0, 0, 3, 1));
    tbl.push_back(v(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 4'b0010, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 0, 4'b0100, 1, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 0, 0, 4'b1111, 1, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(0, 1, 0, 4'b0110, 0, 0, 1, 1, 0, 2, 2));
    tbl.push_back(v(0, 1, 0, 4'b0000, 0, 0, 1, 0, 0, 2, 2));
    tbl.push_back(v(0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 4'b0100, 0, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 1, 0, 4'b1000, 0, 1, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 1, 0, 4'b0001, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 4'b0001, 0, 1, 1, 0, 1, 0, 1));
    tbl.push_back(v(0, 0, 1, 4'b0001, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 4'b0100, 0, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 1, 0, 4'b1000, 0, 1, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 1, 0, 4'b0001, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b0100, 0, 1, 1, 0, 1, 2, 1));
    tbl.push_back(v(0, 1, 0, 4'b1000, 0, 1, 1, 0, 0, 3, 1));
    tbl.push_back(v(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 4'b0010, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 0, 4'b0100, 1, 1, 1, 0, 0, 2, 1));
    tbl.push_back(v(1, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 1, 4'b0110, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b1010, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b1000, 0, 1, 0, 0, 0, 3, 0));
    tbl.push_back(v(0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 4'b0010, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 4'b0100, 0, 1, 0, 0, 0, 2, 0));
    tbl.push_back(v(0, 1, 0, 4'b1000, 1, 1, 0, 0, 0, 3, 0));

    // Directed table.
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].q);
      chk("tbl_locked", int'(locked), int'(tbl[i].lk));
      chk("tbl_pos_valid", int'(pos_valid), int'(tbl[i].pv));
      chk("tbl_fault", int'(fault), int'(tbl[i].ft));
      chk("tbl_onehot_err", int'(onehot_err), int'(tbl[i].oh));
      chk("tbl_step_err", int'(step_err), int'(tbl[i].st));
      chk("tbl_pos", int'(pos), tbl[i].p);
      chk("tbl_err_count", int'(err_count), tbl[i].cnt);
    end

    // Saturation: five repeated samples after lock are five step errors.
    step(1, 0, 0, 4'b0000);
    step(0, 1, 0, 4'b0001);
    step(0, 1, 0, 4'b0010);
    step(0, 1, 0, 4'b0100);
    step(0, 1, 0, 4'b1000);
    step(0, 1, 0, 4'b0001);
    chk("sat_lock", int'(s_locked), 1);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 4'b0001);
    chk("sat_count_narrow", int'(s_err_count), 3);
    chk("sat_count_wide", int'(err_count), 5);
    chk("sat_fault", int'(s_fault), 1);

    // Randomized traffic against the reference model.
    step(1, 0, 0, 4'b0000);
    for (int k = 0; k < 2000; k++) begin
      int sel;
      logic [W-1:0] q;
      bit r, e, c;
      sel = int'($urandom_range(0, 99));
      if (sel < 75)      q = W'(1 << ((m_prev + 1) % W));
      else if (sel < 88) q = W'(1 << $urandom_range(0, W - 1));
      else               q = W'($urandom_range(0, (1 << W) - 1));
      e = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 99) < 4);
      r = ($urandom_range(0, 199) == 0);
      step(r, e, c, q);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
